interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Ports SHALL be exactly the following, listed as name, direction, width and meaning.
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A_mmu  input  16  MMU address.
REQ-005 Di_mmu  input  8  MMU write data.
REQ-006 Do_mmu  output  8  MMU read data, combinational.
REQ-007 wr_mmu  input  1  MMU write strobe.
REQ-008 rd_mmu  input  1  MMU read strobe.
REQ-009 cs_mmu  input  1  MMU chip select.
REQ-010 irq_src  input  5  level request lines: bit0 VBlank, bit1 STAT, bit2 timer (timerIRQ), bit3 serial, bit4 joypad.
REQ-011 int_req  output  1  interrupt request to the CPU.
REQ-012 int_ack  input  1  CPU acknowledge, four-phase handshake.
REQ-013 int_vector  output  8  registered dispatch vector.

Function
REQ-014 The block SHALL implement registers IF[4:0] at 16'hFF0F and IE[7:0] at 16'hFFFF.
REQ-015 Reads: when cs_mmu && rd_mmu, FF0F SHALL return {3'b111, IF}, FFFF SHALL return IE, and any other address SHALL return 8'h00.
REQ-016 When cs_mmu && rd_mmu is false, Do_mmu SHALL be 8'h00.
REQ-017 Writes: cs_mmu && wr_mmu at FF0F SHALL load IF <= Di_mmu[4:0].
REQ-018 Writes: cs_mmu && wr_mmu at FFFF SHALL load IE <= Di_mmu.
REQ-019 Writes to other addresses SHALL be ignored.
REQ-020 Edge detect: the block SHALL keep irq_src_q, a one-cycle delayed copy of irq_src; rise = irq_src & ~irq_src_q.
REQ-021 A set rise bit SHALL set the corresponding IF bit at that same clock edge.
REQ-022 A level held high SHALL NOT re-set IF after IF is cleared.
REQ-023 pend = IF & IE[4:0].
REQ-024 sel SHALL be the lowest-index set bit of pend (bit0 has highest priority).
REQ-025 FSM states SHALL be IDLE and ACKED.
REQ-026 int_req SHALL be (state==IDLE) && (pend != 0), combinational from registered state.
REQ-027 IDLE -> ACKED SHALL occur on an edge where int_ack=1 and int_req=1; at that edge int_vector <= 8'h40 + 8*sel and IF[sel] is cleared.
REQ-028 In ACKED, int_req SHALL be 0 and int_vector SHALL be held stable.
REQ-029 ACKED -> IDLE SHALL occur on the first edge where int_ack=0.
REQ-030 int_ack=1 while in IDLE with pend==0 SHALL be ignored: no state change, IF unchanged.
REQ-031 IF next-state SHALL be ((FF0F write ? Di_mmu[4:0] : IF) & ~ack_clear) | rise.
REQ-032 Precedence under REQ-031: source rise wins over ack clear, and ack clear wins over MMU write data.
REQ-033 ack_clear SHALL be one-hot(sel), computed from pre-edge IF/IE, and nonzero only on the IDLE->ACKED edge.
REQ-034 An IE write on the acknowledge edge SHALL NOT alter the sel already in use for that edge.
REQ-035 IF and IE changes made while in ACKED SHALL take effect on int_req only after return to IDLE.
REQ-036 IE[7:5] SHALL be stored and read back but SHALL NOT affect pend.

Reset
REQ-037 Assertion of reset SHALL asynchronously force: IF=0, IE=0, irq_src_q=0, state=IDLE, int_vector=8'h00.
REQ-038 During reset, int_req SHALL be 0.
REQ-039 Because irq_src_q resets to 0, a source already high at reset release SHALL set its IF bit on the first clock edge after release.
REQ-040 Reset asserted in ACKED SHALL return the FSM to IDLE with no pending acknowledge.

Verification
REQ-041 IE=8'h04, pulse irq_src[2] -> IF=5'h04 after the edge, int_req=1, int_ack=1 -> int_vector=8'h50, IF=0, int_req=0; int_ack=0 -> IDLE.
REQ-042 IE=8'h1F, IF written 5'h1A -> acknowledge yields int_vector=8'h48 and IF=5'h18.
REQ-043 Acknowledge edge coincides with an FF0F write of 5'h1F and a rise on bit0 -> IF=5'h1F, int_vector=8'h40.
REQ-044 irq_src[3] held high for 20 cycles, IF cleared by a write at cycle 5 -> IF[3] stays 0.
REQ-045 Reads return FF0F=8'hE0 after reset, FFFF=8'hA5 after writing IE=8'hA5, FF10=8'h00, and Do_mmu=8'h00 when cs_mmu=0.
REQ-046 Reset asserted mid-ACKED with int_vector=8'h60 -> int_vector=8'h00, IDLE, int_req=0 immediately.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers on the MMU bus, rising-edge source capture,
// fixed-priority selection and a four-phase request/acknowledge handshake to the CPU.
module interrupt_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A_mmu,
    input  logic [7:0]  Di_mmu,
    output logic [7:0]  Do_mmu,
    input  logic        wr_mmu,
    input  logic        rd_mmu,
    input  logic        cs_mmu,
    input  logic [4:0]  irq_src,
    output logic        int_req,
    input  logic        int_ack,
    output logic [7:0]  int_vector
);

    localparam logic [15:0] AddrIf = 16'hFF0F;
    localparam logic [15:0] AddrIe = 16'hFFFF;

    typedef enum logic {StIdle, StAcked} state_e;

    state_e      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  irq_src_q;
    logic [7:0]  vector_q, vector_d;

    logic [4:0]  rise;
    logic [4:0]  pend;
    logic [2:0]  sel;
    logic [4:0]  ack_clear;
    logic        ack_fire;
    logic        if_wr;
    logic        ie_wr;

    assign rise     = irq_src & ~irq_src_q;
    // IE[7:5] is storage only
    assign pend     = if_q & ie_q[4:0];
    assign int_req  = (state_q == StIdle) && (pend != 5'd0);
    assign ack_fire = int_req && int_ack;
    assign if_wr    = cs_mmu && wr_mmu && (A_mmu == AddrIf);
    assign ie_wr    = cs_mmu && wr_mmu && (A_mmu == AddrIe);
    assign int_vector = vector_q;

    // Lowest set bit wins; scanning down leaves the lowest index last.
    always_comb begin
        sel = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign ack_clear = ack_fire ? (5'd1 << sel) : 5'd0;

    always_comb begin
        if_d     = ((if_wr ? Di_mmu[4:0] : if_q) & ~ack_clear) | rise;
        ie_d     = ie_wr ? Di_mmu : ie_q;
        vector_d = ack_fire ? (8'h40 + {2'b00, sel, 3'b000}) : vector_q;
        state_d  = state_q;
        unique case (state_q)
            StIdle:  if (ack_fire) state_d = StAcked;
            StAcked: if (!int_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Do_mmu = 8'h00;
        if (cs_mmu && rd_mmu) begin
            if (A_mmu == AddrIf) begin
                Do_mmu = {3'b111, if_q};
            end else if (A_mmu == AddrIe) begin
                Do_mmu = ie_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            if_q      <= 5'd0;
            ie_q      <= 8'd0;
            irq_src_q <= 5'd0;
            vector_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            if_q      <= if_d;
            ie_q      <= ie_d;
            irq_src_q <= irq_src;
            vector_q  <= vector_d;
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: stimulus queues expected read/vector results,
// a negedge monitor pops and compares whenever a read or a completed handshake appears.
module tb_interrupt_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] A_mmu;
    logic [7:0]  Di_mmu;
    logic [7:0]  Do_mmu;
    logic        wr_mmu;
    logic        rd_mmu;
    logic        cs_mmu;
    logic [4:0]  irq_src;
    logic        int_req;
    logic        int_ack;
    logic [7:0]  int_vector;

    interrupt_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .A_mmu      (A_mmu),
        .Di_mmu     (Di_mmu),
        .Do_mmu     (Do_mmu),
        .wr_mmu     (wr_mmu),
        .rd_mmu     (rd_mmu),
        .cs_mmu     (cs_mmu),
        .irq_src    (irq_src),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_vector (int_vector)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       req;
        logic [7:0] vec;
    } rd_exp_t;

    typedef struct {
        string      name;
        logic [7:0] vec;
    } vec_exp_t;

    rd_exp_t  rq[$];
    vec_exp_t vq[$];
    int checks   = 0;
    int failures = 0;
    logic fire_prev = 1'b0;

    always @(negedge clock) begin
        if (fire_prev) begin
            if (vq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: vector=%02h with no acknowledge expected", int_vector);
            end else begin
                vec_exp_t e;
                e = vq.pop_front();
                checks++;
                if (int_vector !== e.vec) begin
                    failures++;
                    $display("FAIL %s vector: got %02h want %02h", e.name, int_vector, e.vec);
                end
                checks++;
                if (int_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s acked_req: got %b want 0", e.name, int_req);
                end
            end
        end
        fire_prev = int_req && int_ack;
        if (rd_mmu) begin
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: Do_mmu=%02h with no read expected", Do_mmu);
            end else begin
                rd_exp_t r;
                r = rq.pop_front();
                checks++;
                if (Do_mmu !== r.data) begin
                    failures++;
                    $display("FAIL %s data: got %02h want %02h", r.name, Do_mmu, r.data);
                end
                checks++;
                if (int_req !== r.req) begin
                    failures++;
                    $display("FAIL %s int_req: got %b want %b", r.name, int_req, r.req);
                end
                checks++;
                if (int_vector !== r.vec) begin
                    failures++;
                    $display("FAIL %s int_vector: got %02h want %02h", r.name, int_vector, r.vec);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cs_mmu = 1'b1; wr_mmu = 1'b1; A_mmu = a; Di_mmu = d;
        cyc();
        cs_mmu = 1'b0; wr_mmu = 1'b0;
    endtask

    task automatic rd(input logic c, input logic [15:0] a, input logic [7:0] d,
                      input logic r, input logic [7:0] v, input string n);
        rd_exp_t e;
        e.name = n; e.data = d; e.req = r; e.vec = v;
        rq.push_back(e);
        cs_mmu = c; rd_mmu = 1'b1; A_mmu = a;
        cyc();
        cs_mmu = 1'b0; rd_mmu = 1'b0;
    endtask

    task automatic expect_vec(input logic [7:0] v, input string n);
        vec_exp_t e;
        e.name = n; e.vec = v;
        vq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; A_mmu = 16'h0; Di_mmu = 8'h0; wr_mmu = 1'b0; rd_mmu = 1'b0;
        cs_mmu = 1'b0; irq_src = 5'h0; int_ack = 1'b0;
        cyc(); cyc();
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h00, "in_reset_if");
        reset = 1'b0;

        // register access
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h00, "rst_if");
        wr(16'hFFFF, 8'hA5);
        rd(1'b1, 16'hFFFF, 8'hA5, 1'b0, 8'h00, "ie_a5");
        rd(1'b1, 16'hFF10, 8'h00, 1'b0, 8'h00, "other_addr");
        rd(1'b0, 16'hFF0F, 8'h00, 1'b0, 8'h00, "no_cs");

        // timer pulse and full handshake
        wr(16'hFFFF, 8'h04);
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        rd(1'b1, 16'hFF0F, 8'hE4, 1'b1, 8'h00, "timer_pend");
        int_ack = 1'b1; expect_vec(8'h50, "timer_ack"); cyc();
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h50, "timer_acked");
        int_ack = 1'b0; cyc();
        rd(1'b1, 16'hFFFF, 8'h04, 1'b0, 8'h50, "timer_idle");

        // acknowledge with nothing pending is ignored
        int_ack = 1'b1; cyc(); cyc(); int_ack = 1'b0;
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        rd(1'b1, 16'hFF0F, 8'hE4, 1'b1, 8'h50, "spurious_ack_idle");
        wr(16'hFF0F, 8'h00);

        // priority among several pending
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h1A);
        rd(1'b1, 16'hFF0F, 8'hFA, 1'b1, 8'h50, "multi_pend");
        int_ack = 1'b1; expect_vec(8'h48, "multi_ack"); cyc();
        rd(1'b1, 16'hFF0F, 8'hF8, 1'b0, 8'h48, "multi_acked");
        int_ack = 1'b0; cyc();
        rd(1'b1, 16'hFF0F, 8'hF8, 1'b1, 8'h48, "multi_idle");

        // ack edge coinciding with IF write and bit0 rise
        wr(16'hFF0F, 8'h01);
        int_ack = 1'b1; cs_mmu = 1'b1; wr_mmu = 1'b1; A_mmu = 16'hFF0F; Di_mmu = 8'h1F;
        irq_src = 5'h01; expect_vec(8'h40, "prec_ack"); cyc();
        cs_mmu = 1'b0; wr_mmu = 1'b0; irq_src = 5'h00;
        rd(1'b1, 16'hFF0F, 8'hFF, 1'b0, 8'h40, "prec_acked");
        int_ack = 1'b0; cyc();
        rd(1'b1, 16'hFF0F, 8'hFF, 1'b1, 8'h40, "prec_idle");
        wr(16'hFF0F, 8'h00);

        // held level does not re-set IF after clear
        irq_src = 5'h08; cyc();
        rd(1'b1, 16'hFF0F, 8'hE8, 1'b1, 8'h40, "level_set");
        cyc(); cyc();
        wr(16'hFF0F, 8'h00);
        for (int i = 0; i < 14; i++) cyc();
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h40, "level_held");
        irq_src = 5'h00;

        // reset in ACKED
        wr(16'hFF0F, 8'h10);
        int_ack = 1'b1; expect_vec(8'h60, "joy_ack"); cyc();
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h60, "joy_acked");
        reset = 1'b1; irq_src = 5'h02;
        rd(1'b1, 16'hFFFF, 8'h00, 1'b0, 8'h00, "reset_acked");
        int_ack = 1'b0; cyc();
        reset = 1'b0; cyc();
        rd(1'b1, 16'hFF0F, 8'hE2, 1'b0, 8'h00, "src_high_at_release");
        wr(16'hFFFF, 8'h02);
        rd(1'b1, 16'hFFFF, 8'h02, 1'b1, 8'h00, "post_reset_req");
        int_ack = 1'b1; irq_src = 5'h00; expect_vec(8'h48, "post_reset_ack"); cyc();
        rd(1'b1, 16'hFF0F, 8'hE0, 1'b0, 8'h48, "post_reset_acked");
        int_ack = 1'b0; cyc(); cyc();

        checks++;
        if (rq.size() != 0 || vq.size() != 0) begin
            failures++;
            $display("FAIL drain: reads left %0d want 0, vectors left %0d want 0",
                     rq.size(), vq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
